nms_stream: RTL and testbench
=============================

# nms_stream

Streaming non-maximum suppression for the corner-detection pipeline, taking one pixel per accepted cycle in raster order. It sits directly after the corner score stage and generalises the fixed 3x3 comparator. It buffers rows internally, so the upstream stage no longer has to present a full neighbourhood. Score width, window size and image geometry are parameters. Tie-breaking is deterministic and neighbours that are not corners are masked.

## Interface
- SCORE_W, 34: corner score width (unsigned).
- COORD_W, 10: coordinate width; must satisfy 2^COORD_W >= max(IMG_W, IMG_H).
- IMG_W, 640: pixels per row.
- IMG_H, 480: rows per frame.
- WIN, 3: window size; legal values are 3 and 5. R = (WIN-1)/2.

- clk  in  1  single clock; everything is posedge.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; when low, all state holds.
- in_valid  in  1  pixel present this cycle (consumed only when ce=1).
- in_sof  in  1  start of frame; qualified by in_valid; forces this pixel to (0,0).
- in_score  in  SCORE_W  corner score of the pixel.
- in_corner  in  1  pixel passed the corner test.
- out_valid  out  1  one-cycle pulse: a surviving corner is reported.
- out_x  out  COORD_W  x of the reported corner.
- out_y  out  COORD_W  y of the reported corner.

## Operation
- **Accept.** A pixel is accepted when ce & in_valid.
- **Raster counters.** Counters x_cnt and y_cnt give the position of the accepted pixel.
  - Pixel position: in_sof=1 gives (0,0); otherwise it is (x_cnt, y_cnt).
  - Advance after an accept: x wraps at IMG_W-1 to 0 and increments y; y wraps at IMG_H-1 to 0.
- **Masking.** The stored value is m = in_corner ? in_score : 0, together with the in_corner flag.
- **Row storage.** WIN-1 line buffers, each IMG_W deep, hold the previous rows.
- **Window.** A WIN x WIN shift window is updated on each accept.
  - Accepting pixel (x,y) completes the window centred at (cx, cy) = (x-R, y-R).
- **Border.** The centre is suppressed when cx < R, cx > IMG_W-1-R, cy < R or cy > IMG_H-1-R.
  - Border pixels are never reported.
  - The window is only meaningful when the centre is not on the border. Stale line-buffer contents and data across row or frame seams therefore never matter.
  - No end-of-frame flush is needed.
- **Survival rule.** The centre C survives when all of the following hold:
  - C's corner flag is 1 and it is not a border pixel.
  - C >= every neighbour that precedes it in raster order.
  - C > every neighbour that follows it in raster order.
  - On equal scores, only the latest pixel in raster order of a plateau can survive.
- **Output.** A survivor drives out_valid=1 with out_x=cx and out_y=cy. Non-survivors produce no output.
- **Arithmetic.** Comparisons are unsigned at full SCORE_W. Coordinate subtraction is done at COORD_W and is only used when the centre is not a border pixel, so it never underflows.

## Timing
- **Pipeline.** 2 ce-cycles from accept to out_valid.
  - Stage 1 registers the WIN*WIN-1 comparison bits, the centre flag and the coordinates.
  - Stage 2 registers the AND reduction onto out_valid, out_x and out_y.
- **Stall.** With ce=0 the pipeline, counters, window and outputs all freeze. out_valid holds its value.
- **Gaps.** A cycle with in_valid=0 and ce=1 pushes a bubble: the stage valid bits become 0 and the window does not shift.
- **Reset values.** Both stage valid bits, out_valid, out_x, out_y, x_cnt and y_cnt are 0. Line buffer and window contents are not reset.
- **Reset mid-frame.** out_valid=0 from the cycle after rst. The next accepted pixel is (0,0) regardless of in_sof.
- **in_sof mid-row.**
  - The counters restart.
  - Windows straddling the restart are border windows or are overwritten before use, so they cannot produce output.
  - The first 2R rows of the new frame produce nothing.
- **Simultaneous events.** rst has priority over ce. in_sof without in_valid is ignored.

## Structure
- **Package nms_pkg** holds:
  - the raster-order neighbour class function `is_before(dr, dc)`, which returns dr<0 or (dr==0 and dc<0);
  - the legal-WIN check;
  - localparam R.
- **Sub-module nms_line_buffer** (parameters DEPTH and W): a circular RAM with one read and one write per accept, indexed by x. Read-before-write gives the previous row at the same x. One instance is used per stored row, chained.
- **Top level** contains the counters, the window shift registers, the comparison stage and the reduction stage.

## Test plan
Bench configuration: IMG_W=16, IMG_H=8, WIN=3, continuous in_valid and ce=1 unless noted.
1. **Isolated peak.**
   - Stimulus: all scores 0 except (5,3)=100 with corner=1.
   - Required: exactly one out_valid, with out_x=5 and out_y=3, 2 cycles after pixel (6,4) is accepted.
2. **Tie plateau.**
   - Stimulus: (5,3) and (6,3) both 50 with corner=1.
   - Required: only (6,3) is reported.
   - Stimulus: (5,3) and (5,4) both 50 with corner=1.
   - Required: only (5,4) is reported.
3. **Masking and border.**
   - Stimulus: (5,3)=80 with corner=0, surrounded by 90 values with corner=0.
   - Required: nothing is reported.
   - Stimulus: (0,3)=200 with corner=1.
   - Required: nothing is reported. Repeat with (5,3)=10, corner=1, and neighbours 90 with corner=0: (5,3) is reported.
4. **ce and in_valid gaps.**
   - Stimulus: scenario 1 with ce low every other cycle and random in_valid bubbles.
   - Required: the same single report at (5,3).
   - Required: while ce=0, out_valid, out_x and out_y hold.
5. **Reset and sof mid-frame.**
   - Stimulus: assert rst at pixel (9,2), then feed a new frame with the peak at (5,3).
   - Required: out_valid=0 while rst is asserted; then the single report (5,3).
   - Stimulus: in_sof at (7,5) of a running frame, then the peak at (5,3).
   - Required: the single report (5,3), with no spurious output.
6. **WIN=5.**
   - Stimulus: a peak at (7,4) of 100 with a neighbour at (9,6) of 100, both corner=1.
   - Required: only (9,6) is reported.
   - Stimulus: a peak at (1,4).
   - Required: suppressed as a border pixel.

Source files
------------

// File: rtl/nms_stream_pkg.sv
// Shared helpers for the streaming non-maximum suppression block:
// window radius, legal-window check and raster-order neighbour classification.
package nms_pkg;

    localparam int unsigned WIN_DEFAULT = 3;

    function automatic int unsigned win_radius(int unsigned win);
        return (win - 1) / 2;
    endfunction

    localparam int unsigned R = win_radius(WIN_DEFAULT);

    function automatic bit win_legal(int unsigned win);
        return (win == 3) || (win == 5);
    endfunction

    // A neighbour precedes the centre when it lies on an earlier row, or
    // on the same row to the left.
    function automatic bit is_before(int dr, int dc);
        return (dr < 0) || ((dr == 0) && (dc < 0));
    endfunction

endpackage

// File: rtl/nms_stream_if.sv
// Pixel-in / corner-out stream bundle for nms_stream.
interface nms_stream_if #(
    parameter int unsigned SCORE_W = 34,
    parameter int unsigned COORD_W = 10
);
    logic               in_valid;
    logic               in_sof;
    logic [SCORE_W-1:0] in_score;
    logic               in_corner;
    logic               out_valid;
    logic [COORD_W-1:0] out_x;
    logic [COORD_W-1:0] out_y;

    modport master (
        output in_valid, in_sof, in_score, in_corner,
        input  out_valid, out_x, out_y
    );

    modport slave (
        input  in_valid, in_sof, in_score, in_corner,
        output out_valid, out_x, out_y
    );
endinterface

// File: rtl/nms_stream_line_buffer.sv
// One stored image row: asynchronous read-before-write RAM indexed by x,
// so the read returns the previous row at the same column.
module nms_line_buffer #(
    parameter  int unsigned DEPTH = 640,
    parameter  int unsigned W     = 35,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem_q [DEPTH];

    assign rdata = mem_q[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end
endmodule

// File: rtl/nms_stream.sv
// Streaming WIN x WIN non-maximum suppression over a raster pixel stream;
// reports surviving corner coordinates two ce-cycles after the completing pixel.
module nms_stream
    import nms_pkg::*;
#(
    parameter int unsigned SCORE_W = 34,
    parameter int unsigned COORD_W = 10,
    parameter int unsigned IMG_W   = 640,
    parameter int unsigned IMG_H   = 480,
    parameter int unsigned WIN     = WIN_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    nms_stream_if.slave  s
);
    localparam int unsigned RAD = win_radius(WIN);
    localparam int unsigned PW  = SCORE_W + 1;
    localparam int unsigned NB  = WIN * WIN - 1;
    localparam int unsigned AW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    if (!win_legal(WIN) || ((64'd1 << COORD_W) < 64'(IMG_W)) || ((64'd1 << COORD_W) < 64'(IMG_H))) begin : g_bad_cfg
        $error("nms_stream: WIN must be 3 or 5 and COORD_W must cover IMG_W and IMG_H");
    end

    logic               accept;
    logic [COORD_W-1:0] px, py;
    logic [COORD_W-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic [SCORE_W-1:0] masked;
    logic [PW-1:0]      col   [WIN];
    logic [PW-1:0]      win_q [WIN][WIN];
    logic [PW-1:0]      win_d [WIN][WIN];
    logic [SCORE_W-1:0] ctr_score;
    logic               ctr_flag, border;
    logic [NB-1:0]      cmp;
    logic               s1_valid_q, s1_valid_d, s1_flag_q, s1_flag_d;
    logic [NB-1:0]      s1_cmp_q, s1_cmp_d;
    logic [COORD_W-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic               out_valid_q, out_valid_d;
    logic [COORD_W-1:0] out_x_q, out_x_d, out_y_q, out_y_d;

    assign accept = ce & s.in_valid;
    assign masked = s.in_corner ? s.in_score : '0;
    assign col[0] = {s.in_corner, masked};

    always_comb begin
        px = s.in_sof ? '0 : x_cnt_q;
        py = s.in_sof ? '0 : y_cnt_q;
    end

    // col[i] is row y-i at column px; each buffer hands its old row to the next.
    for (genvar i = 0; i < WIN - 1; i++) begin : g_lb
        nms_line_buffer #(.DEPTH(IMG_W), .W(PW)) u_lb (
            .clk   (clk),
            .we    (accept),
            .addr  (px[AW-1:0]),
            .wdata (col[i]),
            .rdata (col[i+1])
        );
    end

    always_comb begin
        x_cnt_d = x_cnt_q;
        y_cnt_d = y_cnt_q;
        if (accept) begin
            if (px == COORD_W'(IMG_W - 1)) begin
                x_cnt_d = '0;
                y_cnt_d = (py == COORD_W'(IMG_H - 1)) ? '0 : py + 1'b1;
            end else begin
                x_cnt_d = px + 1'b1;
                y_cnt_d = py;
            end
        end
    end

    // Row index 0 is the newest row, column WIN-1 the newest column.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int unsigned r = 0; r < WIN; r++) begin
                for (int unsigned c = 0; c < WIN - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][WIN-1] = col[r];
            end
        end
    end

    assign ctr_score = win_d[RAD][RAD][SCORE_W-1:0];
    assign ctr_flag  = win_d[RAD][RAD][SCORE_W];
    // Only the lower edges can be hit: the centre always trails the newest pixel by RAD.
    assign border    = (px < COORD_W'(2 * RAD)) | (py < COORD_W'(2 * RAD));

    always_comb begin
        int unsigned k;
        cmp = '0;
        k   = 0;
        for (int unsigned r = 0; r < WIN; r++) begin
            for (int unsigned c = 0; c < WIN; c++) begin
                if (!((r == RAD) && (c == RAD))) begin
                    if (is_before(int'(RAD) - int'(r), int'(c) - int'(RAD))) begin
                        cmp[k] = ctr_score >= win_d[r][c][SCORE_W-1:0];
                    end else begin
                        cmp[k] = ctr_score > win_d[r][c][SCORE_W-1:0];
                    end
                    k++;
                end
            end
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_flag_d   = s1_flag_q;
        s1_cmp_d    = s1_cmp_q;
        s1_x_d      = s1_x_q;
        s1_y_d      = s1_y_q;
        out_valid_d = out_valid_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        if (ce) begin
            s1_valid_d  = s.in_valid;
            s1_flag_d   = ctr_flag & ~border;
            s1_cmp_d    = cmp;
            s1_x_d      = px - COORD_W'(RAD);
            s1_y_d      = py - COORD_W'(RAD);
            out_valid_d = s1_valid_q & s1_flag_q & (&s1_cmp_q);
            if (out_valid_d) begin
                out_x_d = s1_x_q;
                out_y_d = s1_y_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt_q     <= '0;
            y_cnt_q     <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
        end else begin
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
        end
    end

    always_ff @(posedge clk) begin
        win_q     <= win_d;
        s1_flag_q <= s1_flag_d;
        s1_cmp_q  <= s1_cmp_d;
        s1_x_q    <= s1_x_d;
        s1_y_q    <= s1_y_d;
    end

    assign s.out_valid = out_valid_q;
    assign s.out_x     = out_x_q;
    assign s.out_y     = out_y_q;
endmodule

// File: tb/tb_nms_stream.sv
// Directed bench for nms_stream: a 3x3 instance on a 16x8 image and a 5x5
// instance on a 16x12 image, fed whole or partial frames from a score image.
module tb_nms_stream;
    localparam int unsigned SW = 34;
    localparam int unsigned CW = 10;
    localparam int unsigned IW = 16;
    localparam int unsigned H3 = 8;
    localparam int unsigned H5 = 12;

    logic clk = 1'b0;
    logic rst;
    logic ce;
    always #5 clk = ~clk;

    nms_stream_if #(.SCORE_W(SW), .COORD_W(CW)) if3 ();
    nms_stream_if #(.SCORE_W(SW), .COORD_W(CW)) if5 ();

    nms_stream #(.SCORE_W(SW), .COORD_W(CW), .IMG_W(IW), .IMG_H(H3), .WIN(3)) dut3 (
        .clk (clk), .rst (rst), .ce (ce), .s (if3)
    );
    nms_stream #(.SCORE_W(SW), .COORD_W(CW), .IMG_W(IW), .IMG_H(H5), .WIN(5)) dut5 (
        .clk (clk), .rst (rst), .ce (ce), .s (if5)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit ce_last = 1'b0;
    bit rst_last = 1'b1;
    bit ce_ph = 1'b0;
    bit hold_chk = 1'b0;
    logic          hv;
    logic [CW-1:0] hx, hy;

    logic [SW-1:0] img_s [H5][IW];
    bit            img_c [H5][IW];

    int rx3[$], ry3[$], rc3[$];
    int rx5[$], ry5[$];

    always @(posedge clk) begin
        cyc++;
        ce_last = ce;
        rst_last = rst;
    end

    // A report is a ce-edge that leaves out_valid high; ce-low edges must hold outputs.
    always @(negedge clk) begin
        if (ce_last && !rst_last && if3.out_valid === 1'b1) begin
            rx3.push_back(int'(if3.out_x));
            ry3.push_back(int'(if3.out_y));
            rc3.push_back(cyc);
        end
        if (ce_last && !rst_last && if5.out_valid === 1'b1) begin
            rx5.push_back(int'(if5.out_x));
            ry5.push_back(int'(if5.out_y));
        end
        if (hold_chk && !ce_last && !rst_last) begin
            checks++;
            assert ({if3.out_valid, if3.out_x, if3.out_y} === {hv, hx, hy}) else begin
                errors++;
                $error("FAIL ce_hold: observed %b/%0d/%0d required %b/%0d/%0d",
                       if3.out_valid, if3.out_x, if3.out_y, hv, hx, hy);
            end
        end
        hv = if3.out_valid;
        hx = if3.out_x;
        hy = if3.out_y;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_img();
        for (int y = 0; y < int'(H5); y++) begin
            for (int x = 0; x < int'(IW); x++) begin
                img_s[y][x] = '0;
                img_c[y][x] = 1'b0;
            end
        end
    endtask

    task automatic setp(input int x, input int y, input int s, input bit c);
        img_s[y][x] = SW'(s);
        img_c[y][x] = c;
    endtask

    task automatic clear_reps();
        rx3.delete(); ry3.delete(); rc3.delete();
        rx5.delete(); ry5.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ce = 1'b1;
            if3.in_valid = 1'b0; if3.in_sof = 1'b0;
            if5.in_valid = 1'b0; if5.in_sof = 1'b0;
        end
    endtask

    task automatic send_px(input int which, input int x, input int y, input bit sof,
                           input bit gaps, output int acc);
        bit done = 1'b0;
        bit c, v;
        acc = -1;
        while (!done) begin
            @(negedge clk);
            if (gaps) begin
                ce_ph = ~ce_ph;
                c = ce_ph;
                v = ($urandom_range(0, 3) != 0);
            end else begin
                c = 1'b1;
                v = 1'b1;
            end
            ce = c;
            if (which == 3) begin
                if3.in_valid = v; if3.in_sof = sof;
                if3.in_score = img_s[y][x]; if3.in_corner = img_c[y][x];
                if5.in_valid = 1'b0; if5.in_sof = 1'b0;
            end else begin
                if5.in_valid = v; if5.in_sof = sof;
                if5.in_score = img_s[y][x]; if5.in_corner = img_c[y][x];
                if3.in_valid = 1'b0; if3.in_sof = 1'b0;
            end
            @(posedge clk);
            #1;
            if (c && v) begin
                done = 1'b1;
                acc = cyc;
            end
        end
    endtask

    // Feeds npix pixels of a frame (npix<0: whole frame); acc64 = accept cycle of (6,4).
    task automatic frame(input int which, input bit sof, input bit gaps, input int npix,
                         output int acc64);
        int h, a, n;
        h = (which == 3) ? int'(H3) : int'(H5);
        n = 0;
        acc64 = -1;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < int'(IW); x++) begin
                if (npix < 0 || n < npix) begin
                    send_px(which, x, y, sof && x == 0 && y == 0, gaps, a);
                    if (x == 6 && y == 4) acc64 = a;
                    n++;
                end
            end
        end
    endtask

    task automatic report_check(input string tag, input int which, input int n_exp,
                                input int x, input int y);
        int n, ox, oy;
        ox = -1; oy = -1;
        if (which == 3) begin
            n = rx3.size();
            if (n > 0) begin ox = rx3[0]; oy = ry3[0]; end
        end else begin
            n = rx5.size();
            if (n > 0) begin ox = rx5[0]; oy = ry5[0]; end
        end
        chk({tag, "_count"}, n, n_exp);
        if (n_exp > 0 && n > 0) begin
            chk({tag, "_x"}, ox, x);
            chk({tag, "_y"}, oy, y);
        end
    endtask

    initial begin
        int acc;
        rst = 1'b1;
        ce = 1'b1;
        if3.in_valid = 1'b0; if3.in_sof = 1'b0; if3.in_score = '0; if3.in_corner = 1'b0;
        if5.in_valid = 1'b0; if5.in_sof = 1'b0; if5.in_score = '0; if5.in_corner = 1'b0;
        clear_img();
        repeat (3) @(negedge clk);
        chk("rst_valid3", if3.out_valid, 0);
        chk("rst_x3", if3.out_x, 0);
        chk("rst_y3", if3.out_y, 0);
        chk("rst_valid5", if5.out_valid, 0);
        chk("rst_x5", if5.out_x, 0);
        chk("rst_y5", if5.out_y, 0);
        rst = 1'b0;

        // Isolated peak, with the two-cycle latency from pixel (6,4).
        clear_img(); setp(5, 3, 100, 1); clear_reps();
        frame(3, 1'b1, 1'b0, -1, acc); idle(4);
        report_check("peak", 3, 1, 5, 3);
        if (rc3.size() > 0) chk("peak_latency", rc3[0], acc + 1);

        clear_img(); setp(5, 3, 50, 1); setp(6, 3, 50, 1); clear_reps();
        frame(3, 1'b1, 1'b0, -1, acc); idle(4);
        report_check("tie_row", 3, 1, 6, 3);

        clear_img(); setp(5, 3, 50, 1); setp(5, 4, 50, 1); clear_reps();
        frame(3, 1'b1, 1'b0, -1, acc); idle(4);
        report_check("tie_col", 3, 1, 5, 4);

        clear_img();
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) setp(5 + dx, 3 + dy, 90, 0);
        setp(5, 3, 80, 0); clear_reps();
        frame(3, 1'b1, 1'b0, -1, acc); idle(4);
        report_check("masked", 3, 0, 0, 0);

        clear_img(); setp(0, 3, 200, 1); clear_reps();
        frame(3, 1'b1, 1'b0, -1, acc); idle(4);
        report_check("border", 3, 0, 0, 0);

        clear_img();
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) setp(5 + dx, 3 + dy, 90, 0);
        setp(5, 3, 10, 1); clear_reps();
        frame(3, 1'b1, 1'b0, -1, acc); idle(4);
        report_check("mask_nbr", 3, 1, 5, 3);

        // ce toggling with random in_valid bubbles; outputs must freeze on ce-low edges.
        clear_img(); setp(5, 3, 100, 1); clear_reps();
        hold_chk = 1'b1;
        frame(3, 1'b1, 1'b1, -1, acc);
        hold_chk = 1'b0;
        idle(4);
        report_check("gaps", 3, 1, 5, 3);

        // Reset right after (9,2) completes a pending report for (8,1).
        clear_img(); setp(8, 1, 100, 1); clear_reps();
        frame(3, 1'b1, 1'b0, 2 * 16 + 10, acc);
        @(negedge clk);
        rst = 1'b1; ce = 1'b1; if3.in_valid = 1'b0; if3.in_sof = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid_a", if3.out_valid, 0);
        @(negedge clk);
        chk("rst_mid_valid_b", if3.out_valid, 0);
        rst = 1'b0;
        clear_img(); setp(5, 3, 100, 1);
        frame(3, 1'b0, 1'b0, -1, acc); idle(4);
        report_check("rst_mid", 3, 1, 5, 3);

        // in_sof at (7,5) of a running frame holding a 60-plateau and an unfinished peak.
        clear_img();
        for (int y = 4; y <= 5; y++)
            for (int x = 0; x <= 6; x++) setp(x, y, 60, 1);
        setp(10, 4, 150, 1); clear_reps();
        frame(3, 1'b1, 1'b0, 5 * 16 + 7, acc);
        clear_img(); setp(5, 3, 100, 1);
        frame(3, 1'b1, 1'b0, -1, acc); idle(4);
        report_check("sof_mid", 3, 1, 5, 3);

        clear_img(); setp(7, 4, 100, 1); setp(9, 6, 100, 1); clear_reps();
        frame(5, 1'b1, 1'b0, -1, acc); idle(4);
        report_check("win5_tie", 5, 1, 9, 6);

        clear_img(); setp(1, 4, 100, 1); clear_reps();
        frame(5, 1'b1, 1'b0, -1, acc); idle(4);
        report_check("win5_border", 5, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
